int_to_word: RTL
================

# int_to_word

Converts a DATA-bit integer into its decimal ASCII character string, most significant character first, for printing from the Forth core (e.g. the `.` word) over the UART path. It is the inverse of the compiler's word-to-integer parser and uses the same character-array word format, so a string it produces parses back to the same value. Conversion is iterative: a bit-serial divide-by-10 extracts one digit per pass, and each digit is shifted into the word buffer.

## Interface
Parameters:
- WIDTH, 32, maximum word length in characters; the word buffer has WIDTH entries.
- DATA, 32, integer width in bits.
- DATA_WIDTH (localparam), 8, character width.
- WIDTH_BITS (localparam), $clog2(WIDTH)+1, width of the length field.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request a conversion; sampled only in IDLE.
- i_data  input  DATA  integer to convert; captured in the cycle i_start is accepted.
- o_word  output  DATA_WIDTH x WIDTH  characters; index 0 is the first (most significant) character.
- o_len  output  WIDTH_BITS  number of valid characters.
- o_busy  output  1  high from the cycle after acceptance until o_done.
- o_done  output  1  one-cycle pulse when the result is valid.
- o_err  output  1  result does not fit in WIDTH characters; valid with o_done.

## Operation
- States:
  - IDLE
  - DIV: DATA cycles per digit. Restoring division of the working value by 10 yields a quotient and a remainder in 0..9.
  - EMIT: 1 cycle. Shifts o_word[k] into o_word[k+1] for all k, writes "0"+remainder into o_word[0], increments o_len, and replaces the working value with the quotient.
  - SIGN: 1 cycle, signed builds only.
  - DONE: 1 cycle.
- IDLE to DIV when i_start=1:
  - capture the magnitude of i_data;
  - clear o_len, o_err and all o_word entries to 8'h00.
- EMIT exit:
  - quotient != 0: go to DIV;
  - quotient == 0 and negative flag set: go to SIGN;
  - otherwise: go to DONE.
- Input 0 produces the single character "0" with o_len=1. This case needs no special handling: the first division returns remainder 0 and quotient 0.
- Overflow: if EMIT or SIGN would write a character while o_len==WIDTH:
  - the state goes to DONE instead;
  - o_err=1 and o_len=0;
  - o_word contents are don't-care.
- DONE asserts o_done for exactly one cycle and returns to IDLE. o_word, o_len and o_err then hold until the next accepted i_start.
- i_start while busy or in DONE is ignored and is not queued.
- Arithmetic:
  - the working value is DATA bits unsigned;
  - the remainder register is 4 bits;
  - the divider's partial remainder is 5 bits wide (at most 19 before subtracting 10).

## Timing
- Reset, asynchronous: state IDLE; o_word all 8'h00; o_len=0; o_busy=0; o_done=0; o_err=0.
- i_start accepted at edge 0; o_busy=1 from edge 1.
- For N digits, o_done is high in the cycle after edge N*(DATA+1)+1, plus 1 extra cycle when SIGN runs.
- DATA=32, value 12345: 5*33+1 = 166 cycles.
- o_busy falls in the same cycle o_done rises.
- The earliest new i_start is accepted in the cycle after o_done (back in IDLE).
- Reset asserted mid-conversion aborts immediately: outputs take their reset values and no o_done is produced.

## Configuration
- INT_TO_WORD_SIGNED_EN defined:
  - i_data is two's complement;
  - if i_data[DATA-1]=1, the block stores the negative flag and converts the magnitude (-i_data, taken as unsigned DATA bits, so -2^(DATA-1) is handled correctly);
  - SIGN inserts "-" at o_word[0] with the same shift-and-count behaviour as EMIT.
- Undefined: i_data is unsigned, the SIGN state does not exist, and no "-" is ever produced.

## Structure
- Package word_pkg holds:
  - DATA_WIDTH;
  - character constants CHAR_0 ("0") and CHAR_MINUS ("-");
  - the state enum typedef (IDLE, DIV, EMIT, SIGN, DONE).
- The package is shared with the word-to-integer parser.
- Sub-module div10_serial:
  - inputs: i_clk, i_rst_n, start, DATA-bit dividend;
  - outputs: quotient, 4-bit remainder, and a one-cycle valid pulse DATA cycles after start;
  - the top FSM sequences it.

## Test plan
- 12345 unsigned, WIDTH=32 -> o_word[0..4]="12345", o_len=5, o_err=0, o_done exactly 166 cycles after acceptance.
- 0 -> o_word[0]="0", o_len=1; 32'hFFFFFFFF unsigned -> "4294967295", o_len=10.
- Signed build: 32'h80000000 -> "-2147483648", o_len=11; -7 -> "-7", o_len=2.
- WIDTH=4, value 100000 -> o_err=1, o_len=0 with o_done; then value 999 -> "999", o_err=0.
- i_start pulsed mid-conversion -> ignored, result unchanged; i_rst_n low mid-conversion -> all outputs 0, no o_done; next conversion is correct.
- Round trip: a random value fed through int_to_word then the word parser returns the original value for 1000 random inputs.

Source files
------------

// File: rtl/word_pkg.sv
// Definitions shared by the integer/word converters: character width, the
// character codes the converters emit or parse, and the conversion FSM states.
package word_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam logic [DATA_WIDTH-1:0] CHAR_0     = 8'h30;
  localparam logic [DATA_WIDTH-1:0] CHAR_MINUS = 8'h2d;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIV  = 3'd1,
    EMIT = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } word_state_e;

endpackage

// File: rtl/div10_serial.sv
// Bit-serial restoring divide-by-10: the start cycle performs the first step,
// so quotient/remainder are final and valid pulses DATA cycles after start.
module div10_serial #(
  parameter int unsigned DATA = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            start,
  input  logic [DATA-1:0] dividend,
  output logic [DATA-1:0] quotient,
  output logic [3:0]      remainder,
  output logic            valid
);

  localparam int unsigned CNT_W = $clog2(DATA) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [3:0]      rem_in;
  logic [DATA-1:0] sh_in;
  logic [4:0]      part;
  logic            ge;
  logic [3:0]      rem_nxt;
  logic [DATA-1:0] sh_nxt;

  // One restoring step: dividend bits leave at the MSB, quotient bits enter at the LSB.
  always_comb begin
    rem_in  = start ? 4'd0 : remainder;
    sh_in   = start ? dividend : quotient;
    part    = {rem_in, sh_in[DATA-1]};
    ge      = (part >= 5'd10);
    rem_nxt = ge ? 4'(part - 5'd10) : part[3:0];
    sh_nxt  = {sh_in[DATA-2:0], ge};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        quotient  <= sh_nxt;
        remainder <= rem_nxt;
        cnt_q     <= CNT_W'(1);
        run_q     <= 1'b1;
      end else if (run_q) begin
        quotient  <= sh_nxt;
        remainder <= rem_nxt;
        cnt_q     <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA - 1)) begin
          run_q <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/int_to_word.sv
// Integer to decimal ASCII word, most significant character at index 0.
// Define INT_TO_WORD_SIGNED_EN for two's complement input with a leading "-".
module int_to_word
  import word_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned DATA       = 32,
  localparam int unsigned WIDTH_BITS = $clog2(WIDTH) + 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_start,
  input  logic [DATA-1:0]                     i_data,
  output logic [WIDTH-1:0][DATA_WIDTH-1:0]    o_word,
  output logic [WIDTH_BITS-1:0]               o_len,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_err
);

  word_state_e state_q, state_d;

  logic                  accept_c;
  logic                  div_start_c;
  logic [DATA-1:0]       div_dividend_c;
  logic [DATA-1:0]       div_quot;
  logic [3:0]            div_rem;
  logic                  div_valid;
  logic [DATA-1:0]       mag_c;
  logic                  full_c;
  logic [DATA_WIDTH-1:0] char_c;

`ifdef INT_TO_WORD_SIGNED_EN
  logic neg_c;
  logic neg_q;

  // Negation as unsigned DATA bits keeps the most negative value exact.
  always_comb begin
    neg_c = i_data[DATA-1];
    mag_c = neg_c ? (DATA'(0) - i_data) : i_data;
  end
`else
  always_comb mag_c = i_data;
`endif

  assign full_c = (o_len == WIDTH_BITS'(WIDTH));
  assign char_c = (state_q == SIGN) ? CHAR_MINUS : (CHAR_0 + DATA_WIDTH'(div_rem));

  div10_serial #(
    .DATA(DATA)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .start    (div_start_c),
    .dividend (div_dividend_c),
    .quotient (div_quot),
    .remainder(div_rem),
    .valid    (div_valid)
  );

  // Next state; o_done still high means the previous result is being presented.
  always_comb begin
    state_d        = state_q;
    accept_c       = 1'b0;
    div_start_c    = 1'b0;
    div_dividend_c = div_quot;
    case (state_q)
      IDLE: begin
        if (i_start && !o_done) begin
          accept_c       = 1'b1;
          div_start_c    = 1'b1;
          div_dividend_c = mag_c;
          state_d        = DIV;
        end
      end
      DIV: begin
        if (div_valid) state_d = DIV == DIV ? EMIT : EMIT;
      end
      EMIT: begin
        if (full_c) begin
          state_d = DONE;
        end else if (div_quot != '0) begin
          div_start_c = 1'b1;
          state_d     = DIV;
        end
`ifdef INT_TO_WORD_SIGNED_EN
        else if (neg_q) begin
          state_d = SIGN;
        end
`endif
        else begin
          state_d = DONE;
        end
      end
`ifdef INT_TO_WORD_SIGNED_EN
      SIGN: state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, result buffer and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      o_word  <= '0;
      o_len   <= '0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
`ifdef INT_TO_WORD_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      o_busy  <= (state_q == DIV) || (state_q == EMIT) || (state_q == SIGN);
      o_done  <= (state_q == DONE);
      if (accept_c) begin
        o_word <= '0;
        o_len  <= '0;
        o_err  <= 1'b0;
`ifdef INT_TO_WORD_SIGNED_EN
        neg_q  <= neg_c;
`endif
      end
      if ((state_q == EMIT) || (state_q == SIGN)) begin
        if (full_c) begin
          o_err <= 1'b1;
          o_len <= '0;
        end else begin
          o_word <= {o_word[WIDTH-2:0], char_c};
          o_len  <= o_len + WIDTH_BITS'(1);
        end
      end
    end
  end

endmodule
